phy_tx_scheduler: RTL

Front-end controller for the 4-lane PHY transmit path. It buffers each lane's byte stream in a small per-lane FIFO and runs the link FSM (IDLE, TRAIN, ACTIVE, DRAIN). It arbitrates the lanes round-robin onto one byte stream toward the serializer, inserting COM training and IDLE fill characters. It replaces fixed-slot muxing with demand-driven scheduling and drives the "active" indication used by the idle logic.

---
 rtl/phy_tx_pkg.sv | 17 +
 rtl/lane_fifo.sv | 46 ++++
 rtl/phy_tx_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit scheduler: link state encoding,
// default control characters and the lane count.
package phy_tx_pkg;

  localparam int unsigned NUM_LANES = 4;

  localparam logic [7:0] COM_CHAR_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_CHAR_DEF = 8'h7C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO.
// Ports: clk, reset (async active-low), flush (sync clear, wins over push),
//        push/din, pop/dout (show-ahead head), full, empty.
// Pointers carry one extra wrap bit; full = wrap bits differ, index bits equal.
module lane_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, rd_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + (AW+1)'(1);
      if (pop && !empty) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/phy_tx_scheduler.sv
// 4-lane PHY transmit scheduler: per-lane FIFOs, link FSM (IDLE/TRAIN/ACTIVE/DRAIN),
// round-robin lane arbitration and a single output register toward the serializer.
// Ports: clk, reset (async active-low), link_en, data_inN/valid_inN/ready_outN lane
//        inputs, tx_ready/tx_data/tx_valid/tx_is_k/tx_lane serializer side,
//        active (registered ACTIVE flag), state (link state).
module phy_tx_scheduler
  import phy_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TRAIN_LEN  = 8,
  parameter logic [7:0]  COM_CHAR   = COM_CHAR_DEF,
  parameter logic [7:0]  IDLE_CHAR  = IDLE_CHAR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       link_en,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  output logic       ready_out0,
  output logic       ready_out1,
  output logic       ready_out2,
  output logic       ready_out3,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_is_k,
  output logic [1:0] tx_lane,
  output logic       active,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(TRAIN_LEN + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d, k_q, k_d, active_q;
  logic [1:0]     lane_q, lane_d;

  logic [7:0]           din  [NUM_LANES];
  logic [7:0]           dout [NUM_LANES];
  logic [NUM_LANES-1:0] vin, rdy, push, pop, full, empty;
  logic                 accepting, flush, load_en, accept;
  logic                 grant_valid;
  logic [1:0]           grant_lane, idx;

  assign din = '{data_in0, data_in1, data_in2, data_in3};
  assign vin = {valid_in3, valid_in2, valid_in1, valid_in0};
  assign {ready_out3, ready_out2, ready_out1, ready_out0} = rdy;

  assign accepting = (state_q == ST_TRAIN) || (state_q == ST_ACTIVE);
  // Leaving TRAIN on link drop discards anything already queued.
  assign flush     = (state_q == ST_TRAIN) && !link_en;
  assign load_en   = !valid_q || tx_ready;
  assign accept    = valid_q && tx_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign rdy[i]  = !full[i] && accepting;
    assign push[i] = vin[i] && rdy[i];
    lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push[i]),
      .din   (din[i]),
      .pop   (pop[i]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Round-robin: search from the lane after the last grant, wrapping back to it last.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = ptr_q;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_valid && !empty[idx]) begin
        grant_valid = 1'b1;
        grant_lane  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    pop     = '0;
    valid_d = valid_q;
    data_d  = data_q;
    k_d     = k_q;
    lane_d  = lane_q;
    // A free register takes a bubble unless a state below loads a beat.
    if (load_en) begin
      valid_d = 1'b0;
      data_d  = 8'h00;
      k_d     = 1'b0;
      lane_d  = 2'd0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (link_en) begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end
      end
      ST_TRAIN: begin
        if (!link_en) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(accept && k_q);
          // Only issue COMs that still fit in the training budget, so exactly
          // TRAIN_LEN commas go out before the link turns active.
          if (cnt_d == CW'(TRAIN_LEN)) begin
            state_d = ST_ACTIVE;
          end else if (load_en) begin
            valid_d = 1'b1;
            data_d  = COM_CHAR;
            k_d     = 1'b1;
          end
        end
      end
      ST_ACTIVE, ST_DRAIN: begin
        if (state_q == ST_ACTIVE && !link_en) state_d = ST_DRAIN;
        if (state_q == ST_DRAIN && link_en)   state_d = ST_ACTIVE;
        if (load_en) begin
          if (grant_valid) begin
            pop[grant_lane] = 1'b1;
            valid_d         = 1'b1;
            data_d          = dout[grant_lane];
            lane_d          = grant_lane;
            ptr_d           = grant_lane;
          end else if (state_q == ST_ACTIVE || link_en) begin
            valid_d = 1'b1;
            data_d  = IDLE_CHAR;
            k_d     = 1'b1;
          end else begin
            // Draining, all lanes empty and the last beat leaves this edge.
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= 2'd3;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      k_q      <= 1'b0;
      lane_q   <= 2'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      k_q      <= k_d;
      lane_q   <= lane_d;
      active_q <= (state_d == ST_ACTIVE);
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign tx_is_k  = k_q;
  assign tx_lane  = lane_q;
  assign active   = active_q;
  assign state    = state_q;

endmodule
